// File: rtl/sram_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_controller                                                 |
// | Purpose  : Splits 32-bit memory-stage accesses into two 16-bit async SRAM  |
// |            cycles and stalls the pipeline via ready while one is in flight.|
// | Option   : SRAM_CTRL_READ_BUFFER_EN adds a one-entry last-read buffer.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sram_controller #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memREn,
    input  logic        memWEn,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [3:0]  r_waitCnt;
    logic [3:0]  w_nextWaitCnt;
    logic [29:0] r_wordAddr;
    logic [31:0] r_wdata;
    logic        r_isWrite;
    logic [31:0] r_readData;

    logic [31:0] w_mappedAddr;
    logic        w_request;
    logic        w_hit;
    logic        w_start;
    logic        w_lastCycle;
    logic        w_phaseActive;
    logic        w_dqOe;
    logic [15:0] w_dqOut;
    logic        w_unusedBits;

    assign w_mappedAddr = address - BASE_ADDR;
    assign w_request    = memREn | memWEn;
    assign w_start      = (r_state == S_IDLE) && w_request && !w_hit;
    assign w_lastCycle  = (r_waitCnt == 4'd0);
    assign w_unusedBits = ^{w_mappedAddr[1:0], r_wordAddr[29:16]};

`ifdef SRAM_CTRL_READ_BUFFER_EN
    logic        r_bufValid;
    logic [29:0] r_bufAddr;

    // A pure read (write wins when both are requested) to the last fetched word.
    assign w_hit = (r_state == S_IDLE) && memREn && !memWEn && r_bufValid &&
                   (r_bufAddr == w_mappedAddr[31:2]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bufValid <= 1'b0;
            r_bufAddr  <= '0;
        end else if (w_start && memWEn) begin
            r_bufValid <= 1'b0;
        end else if ((r_state == S_DONE) && !r_isWrite) begin
            r_bufValid <= 1'b1;
            r_bufAddr  <= r_wordAddr;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    always_comb begin
        w_nextState   = r_state;
        w_nextWaitCnt = r_waitCnt;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_nextState   = S_LOW;
                    w_nextWaitCnt = c_WAIT_LOAD;
                end
            end
            S_LOW: begin
                if (w_lastCycle) begin
                    w_nextState   = S_HIGH;
                    w_nextWaitCnt = c_WAIT_LOAD;
                end else begin
                    w_nextWaitCnt = r_waitCnt - 4'd1;
                end
            end
            S_HIGH: begin
                if (w_lastCycle) begin
                    w_nextState = S_DONE;
                end else begin
                    w_nextWaitCnt = r_waitCnt - 4'd1;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_waitCnt  <= 4'd0;
            r_wordAddr <= '0;
            r_wdata    <= '0;
            r_isWrite  <= 1'b0;
            r_readData <= '0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_nextWaitCnt;
            if (w_start) begin
                r_wordAddr <= w_mappedAddr[31:2];
                r_wdata    <= writeData;
                r_isWrite  <= memWEn;
            end
            // Sample the bus on the final cycle of each phase, when data has settled longest.
            if (!r_isWrite && w_lastCycle) begin
                if (r_state == S_LOW) begin
                    r_readData[15:0] <= SRAM_DQ;
                end
                if (r_state == S_HIGH) begin
                    r_readData[31:16] <= SRAM_DQ;
                end
            end
        end
    end

    assign w_phaseActive = (r_state == S_LOW) || (r_state == S_HIGH);
    assign SRAM_ADDR     = w_phaseActive ? {r_wordAddr[15:0], (r_state == S_HIGH)} : 18'd0;
    // Strobe released one cycle before the phase ends to hold address/data past WE rise.
    assign SRAM_WE_N     = !(w_phaseActive && r_isWrite && !w_lastCycle);
    assign w_dqOe        = w_phaseActive && r_isWrite;
    assign w_dqOut       = (r_state == S_HIGH) ? r_wdata[31:16] : r_wdata[15:0];
    assign SRAM_DQ       = w_dqOe ? w_dqOut : 16'hzzzz;

    assign SRAM_OE_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    assign readData = r_readData;
    assign ready    = ((r_state == S_IDLE) && !w_request) || (r_state == S_DONE) || w_hit;

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sram_controller                                              |
// | Purpose  : Self-checking bench for sram_controller with a 16-bit SRAM model|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_sram_controller;

    localparam int          W          = 2;
    localparam logic [31:0] BASE       = 32'd1024;
    localparam int          FULL_STALL = 2 * W + 1;
`ifdef SRAM_CTRL_READ_BUFFER_EN
    localparam int HIT_STALL = 0;
    localparam bit BUF_EN    = 1'b1;
`else
    localparam int HIT_STALL = FULL_STALL;
    localparam bit BUF_EN    = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        memREn;
    logic        memWEn;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        ready;
    logic [17:0] sramAddr;
    wire  [15:0] sramDq;
    logic        weN, oeN, ceN, ubN, lbN;

    sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .memREn    (memREn),
        .memWEn    (memWEn),
        .address   (address),
        .writeData (writeData),
        .readData  (readData),
        .ready     (ready),
        .SRAM_ADDR (sramAddr),
        .SRAM_DQ   (sramDq),
        .SRAM_WE_N (weN),
        .SRAM_OE_N (oeN),
        .SRAM_CE_N (ceN),
        .SRAM_UB_N (ubN),
        .SRAM_LB_N (lbN)
    );

    initial forever #5 clk = ~clk;

    // Initial SRAM content, distinct per half-word
    function automatic logic [15:0] pat(input logic [17:0] h);
        return h[15:0] ^ 16'h5A5A ^ {h[17:16], 14'd0};
    endfunction

    // SRAM model: drives the bus whenever the bench is not issuing a write
    logic [15:0] sramArr [0:262143];
    logic        sramInit = 1'b0;
    logic        tbWriteOp;
    assign sramDq = tbWriteOp ? 16'hzzzz : sramArr[sramAddr];

    always @(posedge clk) begin
        if (!sramInit) begin
            for (int i = 0; i < 262144; i++) sramArr[i] <= pat(18'(i));
            sramInit <= 1'b1;
        end else if (weN == 1'b0) begin
            sramArr[sramAddr] <= sramDq;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Word-level reference model
    logic [31:0] refMem [int];
    logic [31:0] refRd;
    bit          bufValid;
    logic [29:0] bufWord;

    function automatic void refReset();
        refRd    = 32'd0;
        bufValid = 1'b0;
        bufWord  = '0;
    endfunction

    function automatic void refAccess(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                      output int es, output logic [31:0] erd);
        logic [31:0] a;
        int idx;
        a   = addr - BASE;
        idx = int'(a[17:2]);
        if (we) begin
            refMem[idx] = wd;
            bufValid    = 1'b0;
            es          = FULL_STALL;
        end else if (BUF_EN && bufValid && bufWord == a[31:2]) begin
            es = 0;
        end else begin
            refRd    = refMem.exists(idx) ? refMem[idx] : {pat({a[17:2], 1'b1}), pat({a[17:2], 1'b0})};
            bufValid = 1'b1;
            bufWord  = a[31:2];
            es       = FULL_STALL;
        end
        erd = refRd;
    endfunction

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            memREn = 1'b0; memWEn = 1'b0; tbWriteOp = 1'b0;
            @(negedge clk);
            chk("idle ready", 32'(ready), 32'd1);
            chk("idle addr", 32'(sramAddr), 32'd0);
        end
    endtask

    task automatic doAccess(input logic re, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input int expStalls, input logic [31:0] expRd, input string name);
        logic [31:0] a;
        logic [17:0] expAddr;
        logic        expWeN;
        int          c;
        a = addr - BASE;
        c = 0;
        @(posedge clk); #1;
        memREn = re; memWEn = we; address = addr; writeData = wd; tbWriteOp = we;
        forever begin
            @(negedge clk);
            if (c >= 1 && c <= W) begin
                expAddr = {a[17:2], 1'b0};
                expWeN  = !(we && c < W);
            end else if (c > W && c <= 2 * W) begin
                expAddr = {a[17:2], 1'b1};
                expWeN  = !(we && c < 2 * W);
            end else begin
                expAddr = 18'd0;
                expWeN  = 1'b1;
            end
            chk({name, " addr"}, 32'(sramAddr), 32'(expAddr));
            chk({name, " we_n"}, 32'(weN), 32'(expWeN));
            if (we && c >= 1 && c <= 2 * W)
                chk({name, " dq"}, 32'(sramDq), (c <= W) ? 32'(wd[15:0]) : 32'(wd[31:16]));
            if (ready) break;
            if (c >= 40) begin
                checks++;
                errors++;
                $display("FAIL %s timeout: ready still 0 after %0d cycles, required %0d", name, c, expStalls);
                break;
            end
            c++;
            @(posedge clk); #1;
        end
        chk({name, " stalls"}, 32'(c), 32'(expStalls));
        chk({name, " readData"}, readData, expRd);
    endtask

    typedef struct {
        logic        re;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        int          stalls;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [31:0] raddr;
        logic [31:0] rwd;
        logic [31:0] erd;
        logic [31:0] d1040;
        int          es;
        int          op;
        logic        re;
        logic        we;

        rst = 1'b1; memREn = 1'b1; memWEn = 1'b0; address = BASE; writeData = 32'd0; tbWriteOp = 1'b0;
        refReset();

        // Reset held two cycles with a pending read
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst we_n", 32'(weN), 32'd1);
            chk("rst readData", readData, 32'd0);
            chk("rst addr", 32'(sramAddr), 32'd0);
            chk("rst ready", 32'(ready), 32'd0);
            chk("rst dq free", 32'(sramDq), 32'(pat(18'd0)));
        end
        @(posedge clk); #1;
        rst = 1'b0; memREn = 1'b0;
        @(negedge clk);
        chk("post-rst ready", 32'(ready), 32'd1);

        d1040 = {pat(18'd9), pat(18'd8)};
        vecs[0] = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, FULL_STALL, 32'd0};
        vecs[1] = '{1'b1, 1'b0, 32'd1028, 32'd0,        FULL_STALL, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b1, 32'd1032, 32'h11112222, FULL_STALL, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b0, 32'd1032, 32'd0,        FULL_STALL, 32'h11112222};
        vecs[4] = '{1'b1, 1'b1, 32'd1036, 32'hCAFEF00D, FULL_STALL, 32'h11112222};
        vecs[5] = '{1'b1, 1'b0, 32'd1036, 32'd0,        FULL_STALL, 32'hCAFEF00D};
        vecs[6] = '{1'b1, 1'b0, 32'd1040, 32'd0,        FULL_STALL, d1040};
        vecs[7] = '{1'b1, 1'b0, 32'd1040, 32'd0,        HIT_STALL,  d1040};
        vecs[8] = '{1'b0, 1'b1, 32'd2000, 32'h0BADC0DE, FULL_STALL, d1040};
        vecs[9] = '{1'b1, 1'b0, 32'd1040, 32'd0,        FULL_STALL, d1040};

        // Back-to-back: each entry starts in the cycle right after the previous DONE
        for (int i = 0; i < 10; i++)
            doAccess(vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].stalls, vecs[i].rd,
                     $sformatf("vec%0d", i));
        idleCycles(2);

        // Reset asserted in the first HIGH cycle of a write
        @(posedge clk); #1;
        memREn = 1'b0; memWEn = 1'b1; address = BASE + 32'd1600; writeData = 32'h12345678; tbWriteOp = 1'b1;
        repeat (W + 1) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstHigh addr", 32'(sramAddr), 32'd801);
        chk("rstHigh we_n pre", 32'(weN), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; memWEn = 1'b0; tbWriteOp = 1'b0;
        for (int i = 0; i < 2 * W + 2; i++) begin
            @(negedge clk);
            chk("rstHigh we_n", 32'(weN), 32'd1);
            chk("rstHigh ready", 32'(ready), 32'd1);
            chk("rstHigh addr0", 32'(sramAddr), 32'd0);
            chk("rstHigh readData", readData, 32'd0);
        end
        refReset();

        // Randomized traffic against the reference model
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0)
                raddr = BASE - 32'(4 * ($urandom_range(0, 7) + 1)) + 32'($urandom_range(0, 3));
            else
                raddr = BASE + 32'h1000 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            rwd = $urandom;
            op  = int'($urandom_range(0, 9));
            re  = (op >= 4);
            we  = (op <= 3) || (op == 9);
            refAccess(we, raddr, rwd, es, erd);
            doAccess(re, we, raddr, rwd, es, erd, $sformatf("rnd%0d", n));
            if ($urandom_range(0, 4) == 0) idleCycles(1 + int'($urandom_range(0, 2)));
        end
        idleCycles(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
